uart_stream_bridge: RTL

AXI-Lite master that drives one axi_uart register window on behalf of on-chip logic with no CPU, such as a boot loader or a debug monitor. It converts byte streams (valid/ready) into polled accesses to the UART's RX, TX, status and control registers. It sits directly upstream of the UART on its S_AXI_LITE port and consumes the received bytes.

---
 rtl/uart_stream_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge: AXI-Lite master that polls an axi_uart and bridges its RX/TX registers to byte streams.
module uart_stream_bridge #(
    parameter logic [15:0] BASE_ADDR     = 16'h0000,
    parameter int unsigned POLL_INTERVAL = 64
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [15:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [15:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic        uart_irq,
    input  logic [7:0]  tx_tdata,
    input  logic        tx_tvalid,
    output logic        tx_tready,
    output logic [7:0]  rx_tdata,
    output logic        rx_tvalid,
    input  logic        rx_tready,
    output logic        bus_error
);
    typedef enum logic [3:0] {
        INIT, INIT_B, IDLE, STAT_AR, STAT_R, DECIDE, RX_AR, RX_R, TX_AW, TX_B, WAIT
    } state_t;
    state_t      state_q;
    logic [15:0] awaddr_q, araddr_q, cnt_q;
    logic [31:0] wdata_q;
    logic [7:0]  rx_tdata_q;
    logic [4:0]  stat_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic        tx_tready_q, rx_tvalid_q, bus_error_q, prio_q, init_sent_q;
    logic        aw_fin, w_fin, rx_ok, tx_ok, take_rx, unused_ok;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign tx_tready     = tx_tready_q;
    assign rx_tdata      = rx_tdata_q;
    assign rx_tvalid     = rx_tvalid_q;
    assign bus_error     = bus_error_q;
    assign aw_fin  = !awvalid_q || m_axi_awready;
    assign w_fin   = !wvalid_q || m_axi_wready;
    assign rx_ok   = stat_q[0] && !rx_tvalid_q;
    assign tx_ok   = tx_tvalid && !stat_q[3];
    assign take_rx = rx_ok && (!tx_ok || !prio_q);
    assign unused_ok = &{1'b0, m_axi_rdata[31:8], stat_q[4], stat_q[2:1]};
    // prio_q: 0 favours RX, 1 favours TX when both are actionable
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= INIT;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            stat_q      <= '0;
            rx_tdata_q  <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            tx_tready_q <= 1'b0;
            rx_tvalid_q <= 1'b0;
            bus_error_q <= 1'b0;
            prio_q      <= 1'b0;
            init_sent_q <= 1'b0;
        end else begin
            tx_tready_q <= 1'b0;
            if (rx_tvalid_q && rx_tready) rx_tvalid_q <= 1'b0;
            case (state_q)
                INIT, TX_AW: begin
                    if (state_q == INIT && !init_sent_q) begin
                        awaddr_q    <= BASE_ADDR + 16'h000C;
                        wdata_q     <= 32'h13;
                        awvalid_q   <= 1'b1;
                        wvalid_q    <= 1'b1;
                        init_sent_q <= 1'b1;
                    end else begin
                        if (m_axi_awready) awvalid_q <= 1'b0;
                        if (m_axi_wready) wvalid_q <= 1'b0;
                        if (aw_fin && w_fin) begin
                            bready_q <= 1'b1;
                            state_q  <= (state_q == INIT) ? INIT_B : TX_B;
                        end
                    end
                end
                INIT_B, TX_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (|m_axi_bresp) bus_error_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    araddr_q  <= BASE_ADDR + 16'h0008;
                    arvalid_q <= 1'b1;
                    state_q   <= STAT_AR;
                end
                STAT_AR, RX_AR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (state_q == STAT_AR) ? STAT_R : RX_R;
                    end
                end
                STAT_R: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        stat_q   <= (|m_axi_rresp) ? 5'd0 : m_axi_rdata[4:0];
                        if (|m_axi_rresp) bus_error_q <= 1'b1;
                        state_q  <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (take_rx) begin
                        araddr_q  <= BASE_ADDR;
                        arvalid_q <= 1'b1;
                        prio_q    <= 1'b1;
                        state_q   <= RX_AR;
                    end else if (tx_ok) begin
                        tx_tready_q <= 1'b1;
                        awaddr_q    <= BASE_ADDR + 16'h0004;
                        wdata_q     <= {24'h0, tx_tdata};
                        awvalid_q   <= 1'b1;
                        wvalid_q    <= 1'b1;
                        prio_q      <= 1'b0;
                        state_q     <= TX_AW;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                RX_R: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (|m_axi_rresp) bus_error_q <= 1'b1;
                        else begin
                            rx_tdata_q  <= m_axi_rdata[7:0];
                            rx_tvalid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == 16'(POLL_INTERVAL - 1) || (uart_irq && !rx_tvalid_q)) state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end
endmodule
